// File: rtl/mu_if.sv
// Issue/result bus of the RV32M multiply unit.
// master: strb, a, b, mulctl out; mulres, valid in. slave: the reverse.
interface mu_if;
    logic        strb;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mulctl;
    logic [31:0] mulres;
    logic        valid;

    modport master (
        output strb, a, b, mulctl,
        input  mulres, valid
    );

    modport slave (
        input  strb, a, b, mulctl,
        output mulres, valid
    );
endinterface

// File: rtl/mu.sv
// Pipelined 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU), latency 3.
// Ports: clk, rst (sync, active-high), bus (mu_if.slave).
// Optional macro MU_HOLD_RESULT_EN: mulres holds the last result while valid=0.
module mu (
    input  logic clk,
    input  logic rst,
    mu_if.slave  bus
);
    // S1: extended operands and op select
    logic        v1_q, v1_d;
    logic [1:0]  ctl1_q, ctl1_d;
    logic [32:0] a1_q, a1_d;
    logic [32:0] b1_q, b1_d;

    // S2: 16-bit limb partial products
    logic        v2_q, v2_d;
    logic [1:0]  ctl2_q, ctl2_d;
    logic [31:0] pll_q, pll_d;
    logic [33:0] plh_q, plh_d;
    logic [33:0] phl_q, phl_d;
    logic [33:0] phh_q, phh_d;

    // S3: full 64-bit product
    logic        v3_q, v3_d;
    logic [1:0]  ctl3_q, ctl3_d;
    logic [63:0] prod_q, prod_d;

    // Output register
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;

    logic        a_sgn;
    logic        b_sgn;
    logic [33:0] al_x, ah_x, bl_x, bh_x;
    logic [31:0] sel;

    always_comb begin
        a_sgn = (bus.mulctl == 2'b01) || (bus.mulctl == 2'b10);
        b_sgn = (bus.mulctl == 2'b01);

        v1_d   = bus.strb;
        ctl1_d = bus.mulctl;
        a1_d   = {a_sgn & bus.a[31], bus.a};
        b1_d   = {b_sgn & bus.b[31], bus.b};

        // Low limbs are unsigned, high limbs are the signed 17-bit tops.
        // Extending to 34 bits before multiplying keeps each product exact
        // modulo 2^34, and every limb product fits in 34 signed bits.
        al_x = {18'b0, a1_q[15:0]};
        bl_x = {18'b0, b1_q[15:0]};
        ah_x = {{17{a1_q[32]}}, a1_q[32:16]};
        bh_x = {{17{b1_q[32]}}, b1_q[32:16]};

        v2_d   = v1_q;
        ctl2_d = ctl1_q;
        pll_d  = a1_q[15:0] * b1_q[15:0];
        plh_d  = al_x * bh_x;
        phl_d  = ah_x * bl_x;
        phh_d  = ah_x * bh_x;

        v3_d   = v2_q;
        ctl3_d = ctl2_q;
        prod_d = {32'b0, pll_q}
               + ({{30{plh_q[33]}}, plh_q} << 16)
               + ({{30{phl_q[33]}}, phl_q} << 16)
               + ({{30{phh_q[33]}}, phh_q} << 32);

        sel = (ctl3_q == 2'b00) ? prod_q[31:0] : prod_q[63:32];

        valid_d = v3_q;
`ifdef MU_HOLD_RESULT_EN
        res_d = v3_q ? sel : res_q;
`else
        res_d = v3_q ? sel : 32'b0;
`endif
    end

    // Control path and output: cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= 32'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    // Data path: qualified by the valid bits, no reset needed
    always_ff @(posedge clk) begin
        ctl1_q <= ctl1_d;
        a1_q   <= a1_d;
        b1_q   <= b1_d;
        ctl2_q <= ctl2_d;
        pll_q  <= pll_d;
        plh_q  <= plh_d;
        phl_q  <= phl_d;
        phh_q  <= phh_d;
        ctl3_q <= ctl3_d;
        prod_q <= prod_d;
    end

    assign bus.mulres = res_q;
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_mu.sv
// Self-checking bench for mu: directed RV32M cases plus randomized traffic
// compared against a 64-bit arithmetic reference with a due-cycle queue.
module tb_mu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mu_if bus ();

    mu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } pend_t;

    pend_t       pend[$];
    int          total  = 0;
    int          bad    = 0;
    int          edge_n = 0;
    logic [31:0] last   = 32'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] mul_ref(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [1:0]  op);
        logic [63:0] xe, ye, p;
        xe = (op == 2'd1 || op == 2'd2) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (op == 2'd1) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // One clock: apply inputs, update the model at the edge, check after it.
    task automatic step(input string tag, input bit r, input bit s,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] op, input bit fixed,
                        input logic [31:0] want);
        pend_t       e;
        logic        exp_v;
        logic [31:0] exp_r;
        rst        = r;
        bus.strb   = s;
        bus.a      = x;
        bus.b      = y;
        bus.mulctl = op;
        @(posedge clk);
        if (r) begin
            pend.delete();
            last = 32'b0;
        end else if (s) begin
            e.due = edge_n + 3;
            e.val = fixed ? want : mul_ref(x, y, op);
            pend.push_back(e);
        end
        @(negedge clk);
        exp_v = 1'b0;
        exp_r = 32'b0;
`ifdef MU_HOLD_RESULT_EN
        exp_r = last;
`endif
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            exp_v = 1'b1;
            exp_r = pend[0].val;
            last  = exp_r;
            void'(pend.pop_front());
        end
        chk({tag, ".valid"}, {31'b0, bus.valid}, {31'b0, exp_v});
        chk({tag, ".mulres"}, bus.mulres, exp_r);
        edge_n++;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b0, 32'b0, 32'b0, 2'b0, 1'b0, 32'b0);
    endtask

    task automatic op_fix(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [1:0] op,
                          input logic [31:0] want);
        step(tag, 1'b0, 1'b1, x, y, op, 1'b1, want);
    endtask

    initial begin
        bus.strb   = 1'b0;
        bus.a      = 32'b0;
        bus.b      = 32'b0;
        bus.mulctl = 2'b0;

        // Reset with strobe high: ops dropped, outputs quiet
        step("rst", 1'b1, 1'b1, 32'd5, 32'd6, 2'd0, 1'b0, 32'b0);
        step("rst", 1'b1, 1'b1, 32'd9, 32'd9, 2'd3, 1'b0, 32'b0);
        idle("post_rst", 3);

        // Back-to-back -3 * -4 through all four ops
        op_fix("b2b_mul",    32'hFFFFFFFD, 32'hFFFFFFFC, 2'd0, 32'h0000000C);
        op_fix("b2b_mulh",   32'hFFFFFFFD, 32'hFFFFFFFC, 2'd1, 32'h00000000);
        op_fix("b2b_mulhsu", 32'hFFFFFFFD, 32'hFFFFFFFC, 2'd2, 32'hFFFFFFFD);
        op_fix("b2b_mulhu",  32'hFFFFFFFD, 32'hFFFFFFFC, 2'd3, 32'hFFFFFFF9);
        op_fix("mul16x48",   32'd16, 32'd48, 2'd0, 32'd768);
        idle("drain", 5);

        // Corner cases
        op_fix("mulh_min",   32'h80000000, 32'h80000000, 2'd1, 32'h40000000);
        op_fix("mulhu_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 32'hFFFFFFFE);
        op_fix("mulhsu_m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'hFFFFFFFF);
        idle("corner", 5);

        // Reset while three ops are in flight
        op_fix("mid_a", 32'd3, 32'd5, 2'd0, 32'd15);
        op_fix("mid_b", 32'hFFFFFFFF, 32'd2, 2'd1, 32'hFFFFFFFF);
        op_fix("mid_c", 32'd100, 32'd100, 2'd0, 32'd10000);
        step("mid_rst", 1'b1, 1'b0, 32'b0, 32'b0, 2'd0, 1'b0, 32'b0);
        idle("mid_quiet", 4);
        op_fix("mul7x6", 32'd7, 32'd6, 2'd0, 32'd42);
        idle("mul7x6", 5);

        // Randomized traffic with gaps and rare resets
        for (int i = 0; i < 10000; i++) begin
            bit r, s;
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 3) != 0);
            step("rnd", r, s, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 1'b0, 32'b0);
        end
        idle("final", 5);

        chk("queue_empty", pend.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mu.md
Name: mu

Overview:
- Pipelined 32x32 integer multiply unit for the RV32M execute stage.
- Computes MUL, MULH, MULHSU and MULHU.
- Accepts one operation per clock on a strobe and returns the selected 32-bit half of the 64-bit product a fixed 3 cycles later, with a valid flag.

Parameters:
- None. Width is fixed at 32 bits. Pipeline depth is fixed at 3.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- strb  input  1  issue strobe; operands and mulctl sampled on the clk edge where strb=1
- a  input  32  multiplicand (rs1)
- b  input  32  multiplier (rs2)
- mulctl  input  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- mulres  output  32  result
- valid  output  1  mulres holds a completed result this cycle

Behaviour:
- Reset: rst=1 at a rising edge clears all pipeline valid bits. Next cycle valid=0 and mulres=0. Operand/data registers may also be cleared.
- Reset mid-operation: any in-flight operations are discarded, and no valid is produced for them.
- Issue: no ready/backpressure. strb is accepted every cycle, and back-to-back issue is legal (full throughput).
- a, b and mulctl need only be stable at the sampling edge. mulctl travels down the pipeline with its operands, so a later change cannot affect an in-flight op.
- Latency: op sampled at edge N gives valid=1 and the result on mulres after edge N+3, held for exactly one cycle. Without a new op behind it, valid falls after edge N+4.
- Operand extension to 33 bits:
  - a is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - b is sign-extended for MULH only, zero-extended otherwise.
  - The product is the signed 66-bit product, truncated to 64 bits.
- Result select:
  - MUL returns product[31:0], identical for any signedness.
  - MULH, MULHSU and MULHU return product[63:32].
- Suggested stage split (internal, not normative beyond total latency):
  - S1: register extended operands and ctl.
  - S2: register partial products, e.g. 16-bit limbs with sign-correction terms.
  - S3: final sum, half select, register output.
- Output: mulres is a register, updated only when the S3 valid bit is set. When valid=0, mulres=0 unless MU_HOLD_RESULT_EN is defined (see Optional Feature).
- No exceptions. Overflow wraps per the RISC-V spec: MULH of 0x80000000*0x80000000 returns 0x40000000.
- rst and strb both high at the same edge: reset wins and the op is dropped.

Optional Feature:
- Macro MU_HOLD_RESULT_EN.
- Defined: mulres keeps the last valid result when valid=0, and resets to 0.
- Undefined: mulres is forced to 0 in every cycle where valid=0.
- valid timing is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with strb=1 -> valid=0 and mulres=0 throughout, and for 3 cycles after rst drops unless strb is still issuing.
- Back-to-back ops, a=-3 (0xFFFFFFFD), b=-4 (0xFFFFFFFC), issued 1 cycle apart:
  - mulctl=00 -> 0x0000000C
  - mulctl=01 -> 0x00000000
  - mulctl=10 -> 0xFFFFFFFD
  - mulctl=11 -> 0xFFFFFFF9
  - Results appear in 4 consecutive cycles starting 3 cycles after the first issue, with valid=1 each cycle.
- Next cycle: a=16, b=48, mulctl=00 -> mulres=768 three cycles later. Then valid=0, and mulres=0 (or held at 768 with MU_HOLD_RESULT_EN).
- Corner case MULH: 0x80000000*0x80000000 -> 0x40000000.
- Corner case MULHU: 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Corner case MULHSU: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Mid-flight reset: issue 3 ops, assert rst 1 cycle after the last issue -> no valid pulse for any of the 3 ops. Then issue MUL 7*6 -> 42 with latency 3.
- Random: 10k random a/b/mulctl with random strb gaps, checked against a 64-bit reference model -> exact match, valid only 3 cycles after each strb.
